// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: fetches operands, drives a one-cycle ALU enable,
// captures result and flags, then writes back to the register file.
module alu_exec_ctrl #(
  parameter int DATA_W = 16,
  parameter int RA_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [RA_W-1:0]   in_rd,
  input  logic [RA_W-1:0]   in_rs1,
  input  logic [RA_W-1:0]   in_rs2,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
  output logic [RA_W-1:0]   rf_raddr1,
  output logic [RA_W-1:0]   rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic              rf_we,
  output logic [RA_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [3:0]        alu_op,
  output logic              alu_en,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  input  logic              alu_negative,
  output logic [3:0]        flags_q,
  output logic              done,
  output logic              illegal
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_CMP = 4'b0011;

  function automatic logic op_legal(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
  endfunction

  // CMP is a subtract whose result is discarded.
  function automatic logic [3:0] alu_code(input logic [3:0] op);
    return (op == OP_CMP) ? OP_SUB : op;
  endfunction

  state_t              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic [RA_W-1:0]     raddr1_q, raddr1_d, raddr2_q, raddr2_d;
  logic                rf_we_q, rf_we_d;
  logic [RA_W-1:0]     waddr_q, waddr_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [3:0]          alu_op_q, alu_op_d;
  logic                alu_en_q, alu_en_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]          flags_d;
  logic                done_q, done_d;
  logic                illegal_q, illegal_d;

  // Instruction fields held for the life of one instruction.
  logic [3:0]          op_q;
  logic [RA_W-1:0]     rd_q;
  logic                use_imm_q;
  logic [DATA_W-1:0]   imm_q;

  always_comb begin
    state_d    = state_q;
    in_ready_d = 1'b0;
    raddr1_d   = raddr1_q;
    raddr2_d   = raddr2_q;
    rf_we_d    = 1'b0;
    waddr_d    = waddr_q;
    result_d   = result_q;
    alu_op_d   = alu_op_q;
    alu_en_d   = 1'b0;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    flags_d    = flags_q;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          raddr1_d = in_rs1;
          raddr2_d = in_rs2;
          state_d  = READ;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      READ: begin
        if (op_legal(op_q)) begin
          alu_a_d  = rf_rdata1;
          alu_b_d  = use_imm_q ? imm_q : rf_rdata2;
          alu_op_d = alu_code(op_q);
          alu_en_d = 1'b1;
          state_d  = EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = WB;
        end
      end
      EXEC: begin
        result_d = alu_result;
        waddr_d  = rd_q;
        flags_d  = {alu_negative, alu_overflow, alu_carry, alu_zero};
        rf_we_d  = (op_q != OP_CMP) && (rd_q != '0);
        done_d   = 1'b1;
        state_d  = WB;
      end
      WB: begin
        in_ready_d = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        in_ready_d = 1'b1;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b1;
      raddr1_q   <= '0;
      raddr2_q   <= '0;
      rf_we_q    <= 1'b0;
      waddr_q    <= '0;
      result_q   <= '0;
      alu_op_q   <= '0;
      alu_en_q   <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      flags_q    <= '0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      raddr1_q   <= raddr1_d;
      raddr2_q   <= raddr2_d;
      rf_we_q    <= rf_we_d;
      waddr_q    <= waddr_d;
      result_q   <= result_d;
      alu_op_q   <= alu_op_d;
      alu_en_q   <= alu_en_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      flags_q    <= flags_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      op_q      <= in_op;
      rd_q      <= in_rd;
      use_imm_q <= in_use_imm;
      imm_q     <= in_imm;
    end
  end

  assign in_ready  = in_ready_q;
  assign rf_raddr1 = raddr1_q;
  assign rf_raddr2 = raddr2_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = waddr_q;
  assign rf_wdata  = result_q;
  assign alu_op    = alu_op_q;
  assign alu_en    = alu_en_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign done      = done_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a behavioural register file and ALU.
module tb_alu_exec_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_use_imm;
  logic [3:0]  in_op;
  logic [2:0]  in_rd, in_rs1, in_rs2;
  logic [15:0] in_imm;
  logic [2:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic [15:0] rf_rdata1, rf_rdata2, rf_wdata;
  logic        rf_we;
  logic [3:0]  alu_op;
  logic        alu_en;
  logic [15:0] alu_a, alu_b, alu_result;
  logic        alu_zero, alu_carry, alu_overflow, alu_negative;
  logic [3:0]  flags_q;
  logic        done, illegal;

  int errors = 0;
  int checks = 0;

  alu_exec_ctrl #(.DATA_W(16), .RA_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_op(alu_op), .alu_en(alu_en), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow), .alu_negative(alu_negative),
    .flags_q(flags_q), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Register file: combinational read, write at clock edge, plus a preload port.
  logic [15:0] rf [8];
  logic        pre_we = 1'b0;
  logic [2:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;
  int          wr_count = 0;

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  always @(posedge clk) begin
    if (pre_we) rf[pre_addr] <= pre_data;
    else if (rf_we && rst_n) begin
      wr_count <= wr_count + 1;
      if (rf_waddr != 3'd0) rf[rf_waddr] <= rf_wdata;
    end
  end

  // ALU: SUB carry is the borrow out.
  logic [16:0] wide;
  always_comb begin
    wide = '0;
    alu_overflow = 1'b0;
    case (alu_op)
      4'b0000: wide = {1'b0, alu_a & alu_b};
      4'b0001: begin
        wide = {1'b0, alu_a} + {1'b0, alu_b};
        alu_overflow = (alu_a[15] == alu_b[15]) && (wide[15] != alu_a[15]);
      end
      4'b0010: begin
        wide = {1'b0, alu_a} - {1'b0, alu_b};
        alu_overflow = (alu_a[15] != alu_b[15]) && (wide[15] != alu_a[15]);
      end
      default: wide = '0;
    endcase
    alu_result   = wide[15:0];
    alu_carry    = wide[16];
    alu_zero     = (wide[15:0] == 16'h0000);
    alu_negative = wide[15];
  end

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Presents one instruction at an IDLE negedge; returns at the READ-cycle negedge.
  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic ui, input logic [15:0] imm);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_use_imm = ui; in_imm = imm;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL rst_alu_en got %b want 0", alu_en); end
    checks++; if (alu_op !== 4'h0) begin errors++; $display("FAIL rst_alu_op got %h want 0", alu_op); end
    checks++; if ({alu_a, alu_b} !== 32'h0) begin errors++; $display("FAIL rst_alu_ab got %h want 0", {alu_a, alu_b}); end
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== 20'h0) begin errors++; $display("FAIL rst_rf_w got %h want 0", {rf_we, rf_waddr, rf_wdata}); end
    checks++; if ({rf_raddr1, rf_raddr2} !== 6'h0) begin errors++; $display("FAIL rst_raddr got %h want 0", {rf_raddr1, rf_raddr2}); end
    checks++; if ({flags_q, done, illegal} !== 6'h0) begin errors++; $display("FAIL rst_status got %h want 0", {flags_q, done, illegal}); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_idle_ready got %b want 1", in_ready); end
  endtask

  task automatic test_add;
    preload(3'd1, 16'h0001); preload(3'd2, 16'hFFFF);
    issue(4'b0001, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL add_busy got %b want 0", in_ready); end
    checks++; if ({rf_raddr1, rf_raddr2} !== {3'd1, 3'd2}) begin errors++; $display("FAIL add_raddr got %h want %h", {rf_raddr1, rf_raddr2}, {3'd1, 3'd2}); end
    checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL add_en_read got %b want 0", alu_en); end
    @(negedge clk);
    checks++; if (alu_en !== 1'b1) begin errors++; $display("FAIL add_en_exec got %b want 1", alu_en); end
    checks++; if ({alu_a, alu_b} !== 32'h0001FFFF) begin errors++; $display("FAIL add_ops got %h want 0001ffff", {alu_a, alu_b}); end
    checks++; if (alu_op !== 4'b0001) begin errors++; $display("FAIL add_op got %b want 0001", alu_op); end
    @(negedge clk);
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd3, 16'h0000}) begin errors++; $display("FAIL add_wb got %h want %h", {rf_we, rf_waddr, rf_wdata}, {1'b1, 3'd3, 16'h0000}); end
    checks++; if ({done, alu_en} !== 2'b10) begin errors++; $display("FAIL add_done got %b want 10", {done, alu_en}); end
    checks++; if (flags_q !== 4'b0011) begin errors++; $display("FAIL add_flags got %b want 0011", flags_q); end
    @(negedge clk);
    checks++; if ({in_ready, rf_we, done} !== 3'b100) begin errors++; $display("FAIL add_idle got %b want 100", {in_ready, rf_we, done}); end
    checks++; if (rf[3] !== 16'h0000) begin errors++; $display("FAIL add_rf3 got %h want 0000", rf[3]); end
  endtask

  task automatic test_sub;
    preload(3'd1, 16'h8000); preload(3'd2, 16'h0001);
    issue(4'b0010, 3'd4, 3'd1, 3'd2, 1'b0, 16'h0);
    @(negedge clk);
    checks++; if (alu_op !== 4'b0010) begin errors++; $display("FAIL sub_op got %b want 0010", alu_op); end
    @(negedge clk);
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd4, 16'h7FFF}) begin errors++; $display("FAIL sub_wb got %h want %h", {rf_we, rf_waddr, rf_wdata}, {1'b1, 3'd4, 16'h7FFF}); end
    checks++; if (flags_q !== 4'b0100) begin errors++; $display("FAIL sub_flags got %b want 0100", flags_q); end
    @(negedge clk);
  endtask

  task automatic test_and;
    preload(3'd1, 16'hAAAA); preload(3'd2, 16'h5555);
    issue(4'b0000, 3'd6, 3'd1, 3'd2, 1'b0, 16'h0);
    @(negedge clk);
    checks++; if ({alu_en, alu_op} !== 5'b10000) begin errors++; $display("FAIL and_op got %b want 10000", {alu_en, alu_op}); end
    @(negedge clk);
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd6, 16'h0000}) begin errors++; $display("FAIL and_wb got %h want %h", {rf_we, rf_waddr, rf_wdata}, {1'b1, 3'd6, 16'h0000}); end
    checks++; if (flags_q !== 4'b0001) begin errors++; $display("FAIL and_flags got %b want 0001", flags_q); end
    @(negedge clk);
  endtask

  task automatic test_cmp_imm;
    int w0;
    preload(3'd5, 16'h0010); preload(3'd3, 16'h1234);
    w0 = wr_count;
    issue(4'b0011, 3'd7, 3'd5, 3'd3, 1'b1, 16'h0010);
    @(negedge clk);
    checks++; if ({alu_a, alu_b} !== 32'h00100010) begin errors++; $display("FAIL cmp_ops got %h want 00100010", {alu_a, alu_b}); end
    checks++; if (alu_op !== 4'b0010) begin errors++; $display("FAIL cmp_op got %b want 0010", alu_op); end
    @(negedge clk);
    checks++; if ({rf_we, done} !== 2'b01) begin errors++; $display("FAIL cmp_wb got %b want 01", {rf_we, done}); end
    checks++; if (flags_q !== 4'b0001) begin errors++; $display("FAIL cmp_flags got %b want 0001", flags_q); end
    @(negedge clk);
    checks++; if (wr_count !== w0) begin errors++; $display("FAIL cmp_nowrite got %0d want %0d", wr_count, w0); end
  endtask

  task automatic test_add_rd0;
    preload(3'd6, 16'h7FFF); preload(3'd7, 16'h0001);
    issue(4'b0001, 3'd0, 3'd6, 3'd7, 1'b0, 16'h0);
    repeat (2) @(negedge clk);
    checks++; if ({rf_we, done} !== 2'b01) begin errors++; $display("FAIL rd0_wb got %b want 01", {rf_we, done}); end
    checks++; if (flags_q !== 4'b1100) begin errors++; $display("FAIL rd0_flags got %b want 1100", flags_q); end
    @(negedge clk);
  endtask

  task automatic test_illegal;
    int w0;
    w0 = wr_count;
    issue(4'b0101, 3'd2, 3'd1, 3'd2, 1'b0, 16'h0);
    checks++; if ({in_ready, alu_en, illegal} !== 3'b000) begin errors++; $display("FAIL ill_c1 got %b want 000", {in_ready, alu_en, illegal}); end
    @(negedge clk);
    checks++; if ({illegal, alu_en, rf_we, done} !== 4'b1000) begin errors++; $display("FAIL ill_c2 got %b want 1000", {illegal, alu_en, rf_we, done}); end
    @(negedge clk);
    checks++; if ({in_ready, illegal, alu_en} !== 3'b100) begin errors++; $display("FAIL ill_c3 got %b want 100", {in_ready, illegal, alu_en}); end
    checks++; if (flags_q !== 4'b1100) begin errors++; $display("FAIL ill_flags got %b want 1100", flags_q); end
    checks++; if (wr_count !== w0) begin errors++; $display("FAIL ill_nowrite got %0d want %0d", wr_count, w0); end
  endtask

  task automatic test_mid_reset;
    int w0;
    preload(3'd1, 16'h0003); preload(3'd2, 16'h0004);
    w0 = wr_count;
    issue(4'b0001, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0);
    @(negedge clk);
    checks++; if (alu_en !== 1'b1) begin errors++; $display("FAIL mrst_exec got %b want 1", alu_en); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if ({in_ready, rf_we, done, alu_en} !== 4'b1000) begin errors++; $display("FAIL mrst_ctrl got %b want 1000", {in_ready, rf_we, done, alu_en}); end
    checks++; if (flags_q !== 4'b0000) begin errors++; $display("FAIL mrst_flags got %b want 0000", flags_q); end
    repeat (3) @(negedge clk);
    checks++; if (wr_count !== w0) begin errors++; $display("FAIL mrst_nowrite got %0d want %0d", wr_count, w0); end
    checks++; if (rf[3] !== 16'h1234) begin errors++; $display("FAIL mrst_rf3 got %h want 1234", rf[3]); end
  endtask

  task automatic test_back_to_back;
    preload(3'd1, 16'h0001);
    in_op = 4'b0001; in_rd = 3'd2; in_rs1 = 3'd1; in_rs2 = 3'd1; in_use_imm = 1'b0; in_imm = '0;
    in_valid = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin in_rd = 3'd3; in_rs1 = 3'd2; end
      if (c == 5) in_valid = 1'b0;
      checks++; if (in_ready !== (c == 4 || c == 8)) begin errors++; $display("FAIL b2b_ready c%0d got %b want %b", c, in_ready, (c == 4 || c == 8)); end
      checks++; if (alu_en !== (c == 2 || c == 6)) begin errors++; $display("FAIL b2b_en c%0d got %b want %b", c, alu_en, (c == 2 || c == 6)); end
      checks++; if (done !== (c == 3 || c == 7)) begin errors++; $display("FAIL b2b_done c%0d got %b want %b", c, done, (c == 3 || c == 7)); end
      if (c == 3) begin
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd2, 16'h0002}) begin errors++; $display("FAIL b2b_wb1 got %h want %h", {rf_we, rf_waddr, rf_wdata}, {1'b1, 3'd2, 16'h0002}); end
      end
      if (c == 7) begin
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd3, 16'h0003}) begin errors++; $display("FAIL b2b_wb2 got %h want %h", {rf_we, rf_waddr, rf_wdata}, {1'b1, 3'd3, 16'h0003}); end
      end
    end
    checks++; if (rf[3] !== 16'h0003) begin errors++; $display("FAIL b2b_rf3 got %h want 0003", rf[3]); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_use_imm = 1'b0; in_imm = '0;
    @(negedge clk);
    preload(3'd0, 16'h0000);
    test_reset();
    test_add();
    test_sub();
    test_and();
    test_cmp_imm();
    test_add_rd0();
    test_illegal();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Execute-stage sequencer of the multicycle 16-bit RISC datapath. It sits directly upstream of the ALU and accepts one decoded ALU-class instruction at a time. It reads operands from the register file, drives the ALU's `ALUop`/`ALUen`/`a`/`b` inputs, and captures the result and flags. It then writes the result back to the register file and holds the architectural flag register.

## Interface
Parameters:
- DATA_W, 16, operand/result width
- RA_W, 3, register address width (8 registers)

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
  - clk  in  1  clock, all state on rising edge
  - rst_n  in  1  active-low reset, sampled on rising clk
- Instruction input:
  - in_valid  in  1  decoded instruction present
  - in_ready  out  1  block can accept; high only in IDLE
  - in_op  in  4  0000 AND, 0001 ADD, 0010 SUB, 0011 CMP, others illegal
  - in_rd, in_rs1, in_rs2  in  RA_W each  destination/source registers
  - in_use_imm  in  1  1: operand B = in_imm instead of register rs2
  - in_imm  in  DATA_W  immediate, already sign-extended by the decoder
- Register file:
  - rf_raddr1, rf_raddr2  out  RA_W  read addresses (register file reads are combinational)
  - rf_rdata1, rf_rdata2  in  DATA_W  read data
  - rf_we  out  1  write enable, one-cycle pulse
  - rf_waddr  out  RA_W  write address
  - rf_wdata  out  DATA_W  write data
- ALU:
  - alu_op  out  4  to ALUop
  - alu_en  out  1  to ALUen
  - alu_a, alu_b  out  DATA_W  registered operands
  - alu_result  in  DATA_W  ALU result
  - alu_zero, alu_carry, alu_overflow, alu_negative  in  1 each  ALU flags
- Status:
  - flags_q  out  4  architectural flags {N,V,C,Z}
  - done  out  1  one-cycle pulse, instruction retired
  - illegal  out  1  one-cycle pulse, illegal opcode dropped

## Operation
- FSM states: IDLE, READ, EXEC, WB.
- IDLE: in_ready=1. On in_valid=1, latch op, rd, rs1, rs2, use_imm and imm, then go to READ.
- READ:
  - Drive rf_raddr1=rs1, rf_raddr2=rs2.
  - At the clock edge, register alu_a<=rf_rdata1 and alu_b<=(use_imm ? imm : rf_rdata2).
  - Register alu_op: AND→0000, ADD→0001, SUB→0010, CMP→0010.
  - Illegal op: do not enter EXEC; pulse illegal in the next cycle (the WB slot), no writeback, flags unchanged, then go to IDLE.
- EXEC: alu_en=1 for exactly this cycle. Operands and alu_op are already stable from the prior edge, so the ALU sees a clean 0→1 edge. At the end of EXEC:
  - result_q<=alu_result
  - flags_q<={alu_negative, alu_overflow, alu_carry, alu_zero}, captured verbatim with no recomputation
- WB:
  - alu_en=0, done=1.
  - rf_we=1 with rf_waddr=rd and rf_wdata=result_q, except:
    - CMP: rf_we=0.
    - rd=0: rf_we=0, since R0 is hardwired zero; flags still update.
  - Next state is IDLE.
- alu_a, alu_b and alu_op hold their values outside READ. alu_en is 0 in every state except EXEC.
- Reset values: state=IDLE, in_ready=1 (after reset deasserts), alu_en=0, alu_op=0, alu_a=alu_b=0, rf_we=0, rf_waddr=0, rf_wdata=0, flags_q=0, done=0, illegal=0, rf_raddr1/2=0.
- Reset mid-operation, in any state: return to IDLE next edge. No rf_we, no done, flags_q cleared; a pending writeback is discarded.
- in_valid while busy is ignored; upstream must hold the instruction until it sees in_ready.

## Timing
- Cycle 0: in_valid & in_ready handshake. Cycle 1: READ. Cycle 2: EXEC (alu_en=1). Cycle 3: WB (rf_we, done). Cycle 4: IDLE, in_ready=1.
- Latency: 3 cycles from accept to done. Throughput: one instruction per 4 cycles; with in_valid held high, the next instruction is accepted at cycle 4.
- flags_q is visible from cycle 3 onward.
- Illegal path: accept at cycle 0, READ at cycle 1, illegal pulse at cycle 2, in_ready at cycle 3.
- rf_rdata must be valid in the READ cycle. A write in WB is visible to the next instruction's READ, which is at least 2 cycles later, so no bypass is needed.

## Test plan
- ADD: R1=0x0001, R2=0xFFFF, rd=3 → cycle 3: rf_we=1, waddr=3, wdata=0x0000, done=1; flags_q Z=1, N=0, V=0.
- SUB: R1=0x8000, R2=0x0001, rd=4 → wdata=0x7FFF, V=1, N=0, Z=0. AND: R1=0xAAAA, R2=0x5555 → wdata=0x0000, Z=1, C=0, V=0.
- CMP with use_imm: R5=0x0010, imm=0x0010 → no rf_we, done=1, Z=1. Then ADD with rd=0 → no rf_we, flags updated.
- Illegal op 0101 → illegal pulse at cycle 2, alu_en never rises, rf_we=0, flags_q unchanged, in_ready=1 at cycle 3.
- Back-to-back: in_valid held high with two ADDs → second accepted exactly at cycle 4. alu_en high for exactly one cycle per instruction, returning to 0 between them.
- Reset: rst_n=0 during EXEC → next cycle state IDLE, rf_we=0, done=0, flags_q=0, alu_en=0; no write ever occurs.
